// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg
//   Shared constants and state type for the 5-bit sequential restoring divider.
//   WIDTH : datapath width, matched to the trial subtractor
//   ITER  : iterations per division (one quotient bit per CALC cycle)
//   CNTW  : width of the iteration down-counter
package seq_divider_pkg;

  localparam int WIDTH = 5;
  localparam int ITER  = 5;
  localparam int CNTW  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_sub.sv
// seq_divider_sub
//   Combinational trial subtractor used by the divider every CALC cycle.
//   a   : minuend (shifted partial remainder)
//   b   : subtrahend (divisor)
//   out : a - b, modulo 2^WIDTH
//   co  : 1 when no borrow occurred (a >= b)
module seq_divider_sub
  import seq_divider_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             co
);

  logic [WIDTH:0] diff;

  // Extra top bit is the borrow; invert it to get carry-out.
  assign diff = {1'b0, a} - {1'b0, b};
  assign out  = diff[WIDTH-1:0];
  assign co   = ~diff[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// seq_divider
//   5-bit unsigned restoring divider, one quotient bit per cycle.
//   clk         : clock, rising edge
//   rstn        : asynchronous active-low reset
//   start       : request a division (sampled only in IDLE)
//   dividend    : unsigned dividend, captured on accepted start
//   divisor     : unsigned divisor, captured on accepted start
//   busy        : high in CALC and DONE
//   done        : one-cycle pulse, results valid from this cycle
//   quotient    : result register
//   remainder   : result register
//   div_by_zero : set with done when the captured divisor was 0
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; results held
//   CALC  | one trial subtraction per cycle, cnt counts down 4..0
//   DONE  | done pulse, results valid; returns to IDLE unconditionally
module seq_divider
  import seq_divider_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t           state;
  logic [CNTW-1:0]  cnt;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH-1:0] d_r;

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] sub_out;
  logic             sub_co;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             unused_r_msb;

  // Partial remainder entering an iteration is < 16, so r[4] never feeds t;
  // it is only needed to hold the final remainder.
  assign t            = {r[WIDTH-2:0], q_sh[WIDTH-1]};
  assign unused_r_msb = r[WIDTH-1];

  seq_divider_sub sub_trial (
    .a   (t),
    .b   (d_r),
    .out (sub_out),
    .co  (sub_co)
  );

  assign r_next = sub_co ? sub_out : t;
  assign q_next = {q_sh[WIDTH-2:0], sub_co};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      r           <= '0;
      q_sh        <= '0;
      d_r         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            q_sh <= dividend;
            d_r  <= divisor;
            r    <= '0;
            busy <= 1'b1;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              cnt         <= '0;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state       <= CALC;
              cnt         <= CNTW'(ITER - 1);
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          r    <= r_next;
          q_sh <= q_next;
          if (cnt == '0) begin
            // Results load on the edge into DONE so they are valid with done.
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= r_next;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  logic       clk;
  logic       rstn;
  logic       start;
  logic [4:0] dividend;
  logic [4:0] divisor;
  logic       busy;
  logic       done;
  logic [4:0] quotient;
  logic [4:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int passes = 0;

  seq_divider dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer division, divide-by-zero convention.
  function automatic void model(input int a, input int b,
                                output int q, output int r, output int z, output int lat);
    if (b == 0) begin
      q = 31; r = a; z = 1; lat = 1;
    end else begin
      q = a / b; r = a % b; z = 0; lat = 6;
    end
  endfunction

  // Issue one start and wait (bounded) for done; returns cycles to done and
  // number of cycles busy was seen high up to and including the done cycle.
  task automatic run_div(input int a, input int b, output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; dividend = 5'(a); divisor = 5'(b);
    @(negedge clk);
    start = 1'b0;
    lat = 1; busy_cnt = 0;
    if (busy) busy_cnt++;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 13'd0)
      $display("FAIL reset_outputs got busy=%b done=%b q=%0d r=%0d dbz=%b want all 0",
               busy, done, quotient, remainder, div_by_zero);
    else passes++;
    rstn = 1'b1;
  endtask

  task automatic test_directed();
    int a_tab[5] = '{23, 31, 31, 0, 9};
    int b_tab[5] = '{5, 1, 31, 7, 2};
    int lat, bc, eq, er, ez, el;
    for (int i = 0; i < 5; i++) begin
      run_div(a_tab[i], b_tab[i], lat, bc);
      model(a_tab[i], b_tab[i], eq, er, ez, el);
      checks++;
      if (lat !== el) $display("FAIL dir_latency %0d/%0d got %0d want %0d", a_tab[i], b_tab[i], lat, el);
      else passes++;
      checks++;
      if (quotient !== 5'(eq) || remainder !== 5'(er) || div_by_zero !== ez[0])
        $display("FAIL dir_result %0d/%0d got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%0d",
                 a_tab[i], b_tab[i], quotient, remainder, div_by_zero, eq, er, ez);
      else passes++;
      if (i == 0) begin
        checks++;
        if (bc !== 6) $display("FAIL busy_cycles 23/5 got %0d want 6", bc);
        else passes++;
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0)
        $display("FAIL post_done %0d/%0d got busy=%b done=%b want 0 0", a_tab[i], b_tab[i], busy, done);
      else passes++;
    end
  endtask

  task automatic test_div_by_zero();
    int lat, bc;
    run_div(5, 0, lat, bc);
    checks++;
    if (lat !== 1) $display("FAIL dbz_latency got %0d want 1", lat);
    else passes++;
    checks++;
    if (quotient !== 5'd31 || remainder !== 5'd5 || div_by_zero !== 1'b1)
      $display("FAIL dbz_result got q=%0d r=%0d dbz=%b want q=31 r=5 dbz=1", quotient, remainder, div_by_zero);
    else passes++;
    repeat (3) @(negedge clk);
    checks++;
    if (quotient !== 5'd31 || remainder !== 5'd5 || div_by_zero !== 1'b1)
      $display("FAIL dbz_hold got q=%0d r=%0d dbz=%b want q=31 r=5 dbz=1", quotient, remainder, div_by_zero);
    else passes++;
    run_div(9, 2, lat, bc);
    checks++;
    if (lat !== 6 || quotient !== 5'd4 || remainder !== 5'd1 || div_by_zero !== 1'b0)
      $display("FAIL after_dbz got lat=%0d q=%0d r=%0d dbz=%b want lat=6 q=4 r=1 dbz=0",
               lat, quotient, remainder, div_by_zero);
    else passes++;
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clk);
    start = 1'b1; dividend = 5'd20; divisor = 5'd3;
    @(negedge clk);
    start = 1'b0; lat = 1;
    @(negedge clk); lat++;
    start = 1'b1; dividend = 5'd7; divisor = 5'd7;
    @(negedge clk); lat++;
    start = 1'b0; dividend = 5'd0; divisor = 5'd0;
    while (!done && lat < 20) begin
      @(negedge clk); lat++;
    end
    checks++;
    if (lat !== 6 || quotient !== 5'd6 || remainder !== 5'd2 || div_by_zero !== 1'b0)
      $display("FAIL start_ignored got lat=%0d q=%0d r=%0d dbz=%b want lat=6 q=6 r=2 dbz=0",
               lat, quotient, remainder, div_by_zero);
    else passes++;
    // a start presented during DONE must not be accepted
    start = 1'b1; dividend = 5'd1; divisor = 5'd0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL start_in_done got busy=%b done=%b want 0 0", busy, done);
    else passes++;
  endtask

  task automatic test_reset_mid_calc();
    int seen_done = 0;
    int lat, bc;
    @(negedge clk);
    start = 1'b1; dividend = 5'd20; divisor = 5'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 13'd0)
      $display("FAIL mid_reset got busy=%b done=%b q=%0d r=%0d dbz=%b want all 0",
               busy, done, quotient, remainder, div_by_zero);
    else passes++;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen_done = 1;
    end
    checks++;
    if (seen_done !== 0) $display("FAIL mid_reset_no_done got activity=%0d want 0", seen_done);
    else passes++;
    run_div(12, 4, lat, bc);
    checks++;
    if (lat !== 6 || quotient !== 5'd3 || remainder !== 5'd0 || div_by_zero !== 1'b0)
      $display("FAIL after_reset got lat=%0d q=%0d r=%0d dbz=%b want lat=6 q=3 r=0 dbz=0",
               lat, quotient, remainder, div_by_zero);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int c = 0, d1 = -1, d2 = -1;
    @(negedge clk);
    start = 1'b1; dividend = 5'd29; divisor = 5'd6;
    @(negedge clk);
    dividend = 5'd17; divisor = 5'd4;   // captured only at the next accept
    while (c < 30 && d2 < 0) begin
      c++;
      if (done) begin
        if (d1 < 0) begin
          d1 = c;
          checks++;
          if (quotient !== 5'd4 || remainder !== 5'd5)
            $display("FAIL b2b_first got q=%0d r=%0d want q=4 r=5", quotient, remainder);
          else passes++;
        end else begin
          d2 = c;
          start = 1'b0;
          checks++;
          if (quotient !== 5'd4 || remainder !== 5'd1)
            $display("FAIL b2b_second got q=%0d r=%0d want q=4 r=1", quotient, remainder);
          else passes++;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (d1 !== 6 || d2 - d1 !== 7)
      $display("FAIL b2b_period got first=%0d gap=%0d want first=6 gap=7", d1, d2 - d1);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_random();
    int a, b, lat, bc, eq, er, ez, el;
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, 31));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31));
      run_div(a, b, lat, bc);
      model(a, b, eq, er, ez, el);
      checks++;
      if (lat !== el || quotient !== 5'(eq) || remainder !== 5'(er) || div_by_zero !== ez[0])
        $display("FAIL rand %0d/%0d got lat=%0d q=%0d r=%0d dbz=%b want lat=%0d q=%0d r=%0d dbz=%0d",
                 a, b, lat, quotient, remainder, div_by_zero, el, eq, er, ez);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_by_zero();
    test_start_ignored();
    test_reset_mid_calc();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
